// File: rtl/rstring_ctrl.sv
// Trip-point sequencer for the 8-tap resistor-string mux: code handshake, enable, blanking.
// Optional macro RSTRING_SWEEP_EN adds a `sweep` input that steps through every tap.
module rstring_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic       clk,
    input  logic       rst,
`ifdef RSTRING_SWEEP_EN
    input  logic       sweep,
`endif
    input  logic       en,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic [2:0] otrip_in,
    output logic       ena,
    output logic [7:0] otrip_decoded,
    output logic       blank,
    output logic       ready
);

    localparam logic [1:0] StOff    = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StActive = 2'd2;

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ena_q, ena_d;
    logic [7:0]       dec_q, dec_d;
    logic             blank_q, blank_d;
    logic             ready_q, ready_d;
    logic             sweep_on;
    logic             xfer;

`ifdef RSTRING_SWEEP_EN
    assign sweep_on = sweep;
`else
    assign sweep_on = 1'b0;
`endif

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'h01 << idx;
    endfunction

    assign upd_ready = (state_q != StSettle) && !sweep_on;
    assign xfer      = upd_valid && upd_ready;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        ena_d   = ena_q;
        dec_d   = dec_q;
        blank_d = blank_q;
        ready_d = ready_q;

        case (state_q)
            StOff: begin
                if (xfer) begin
                    code_d = otrip_in;
                end
                if (en) begin
                    // A code offered on the same edge as enable wins over the stored one.
                    state_d = StSettle;
                    ena_d   = 1'b1;
                    dec_d   = onehot(xfer ? otrip_in : code_q);
                    cnt_d   = CntLoad;
                    blank_d = 1'b1;
                    ready_d = 1'b0;
                end
            end
            StSettle: begin
                if (!en) begin
                    state_d = StOff;
                    ena_d   = 1'b0;
                    dec_d   = 8'h00;
                    blank_d = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StActive;
                    blank_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StActive: begin
                if (!en) begin
                    if (xfer) begin
                        code_d = otrip_in;
                    end
                    state_d = StOff;
                    ena_d   = 1'b0;
                    dec_d   = 8'h00;
                    blank_d = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end else if (sweep_on) begin
                    code_d  = code_q + 3'd1;
                    dec_d   = onehot(code_q + 3'd1);
                    state_d = StSettle;
                    cnt_d   = CntLoad;
                    blank_d = 1'b1;
                    ready_d = 1'b0;
                end else if (xfer && (otrip_in != code_q)) begin
                    // One-hot to one-hot in a single edge; never passes through all-zero.
                    code_d  = otrip_in;
                    dec_d   = onehot(otrip_in);
                    state_d = StSettle;
                    cnt_d   = CntLoad;
                    blank_d = 1'b1;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = StOff;
                ena_d   = 1'b0;
                dec_d   = 8'h00;
                blank_d = 1'b1;
                ready_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOff;
            code_q  <= 3'd0;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            dec_q   <= 8'h00;
            blank_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            dec_q   <= dec_d;
            blank_q <= blank_d;
            ready_q <= ready_d;
        end
    end

    assign ena           = ena_q;
    assign otrip_decoded = dec_q;
    assign blank         = blank_q;
    assign ready         = ready_q;

endmodule

// File: tb/tb_rstring_ctrl.sv
// Scoreboard bench for rstring_ctrl: two instances (settle 16 and settle 1) share stimulus
// and are checked every cycle against a tap/settle-time reference model.
module tb_rstring_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       upd_valid = 1'b0;
    logic [2:0] otrip_in = 3'd0;
`ifdef RSTRING_SWEEP_EN
    logic       sweep = 1'b0;
`endif

    logic       upd_ready0, ena0, blank0, ready0;
    logic [7:0] dec0;
    logic       upd_ready1, ena1, blank1, ready1;
    logic [7:0] dec1;

    always #5 clk = ~clk;

    rstring_ctrl #(.SETTLE_CYCLES(16), .CNT_W(5)) u_dut0 (
        .clk           (clk),
        .rst           (rst),
`ifdef RSTRING_SWEEP_EN
        .sweep         (sweep),
`endif
        .en            (en),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready0),
        .otrip_in      (otrip_in),
        .ena           (ena0),
        .otrip_decoded (dec0),
        .blank         (blank0),
        .ready         (ready0)
    );

    rstring_ctrl #(.SETTLE_CYCLES(1), .CNT_W(5)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
`ifdef RSTRING_SWEEP_EN
        .sweep         (sweep),
`endif
        .en            (en),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready1),
        .otrip_in      (otrip_in),
        .ena           (ena1),
        .otrip_decoded (dec1),
        .blank         (blank1),
        .ready         (ready1)
    );

    // Reference model: powered flag, selected tap, and edges remaining until vin is valid.
    int  settle_n[2] = '{16, 1};
    bit  powered[2];
    int  tap[2];
    int  remaining[2];

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [11:0] expect_of(input int i);
        logic       rdy;
        logic       ur;
        logic [7:0] dec;
        rdy = powered[i] && (remaining[i] == 0);
        ur  = !(powered[i] && (remaining[i] > 0));
        dec = powered[i] ? (8'd1 << tap[i]) : 8'd0;
        return {ur, rdy, !rdy, dec, powered[i]};
    endfunction

    task automatic model_step(input int i);
        bit accepted;
        accepted = upd_valid && !(powered[i] && (remaining[i] > 0));
        if (rst) begin
            powered[i]   = 1'b0;
            tap[i]       = 0;
            remaining[i] = 0;
        end else if (!powered[i]) begin
            if (accepted) tap[i] = int'(otrip_in);
            if (en) begin
                powered[i]   = 1'b1;
                remaining[i] = settle_n[i];
            end
        end else if (!en) begin
            if (accepted) tap[i] = int'(otrip_in);
            powered[i]   = 1'b0;
            remaining[i] = 0;
        end else if (remaining[i] > 0) begin
            remaining[i] = remaining[i] - 1;
        end else if (accepted && int'(otrip_in) != tap[i]) begin
            tap[i]       = int'(otrip_in);
            remaining[i] = settle_n[i];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            exp_q0.push_back(expect_of(0));
            exp_q1.push_back(expect_of(1));
        end
    end

    task automatic check_one(input int id, input string name, input logic [7:0] got,
                             input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s at %0t: got %h expected %h", id, name, $time, got, exp);
        end
    endtask

    task automatic check_all(input int id, input logic [11:0] e, input logic [11:0] g);
        check_one(id, "ena", {7'd0, g[0]}, {7'd0, e[0]});
        check_one(id, "otrip_decoded", g[8:1], e[8:1]);
        check_one(id, "blank", {7'd0, g[9]}, {7'd0, e[9]});
        check_one(id, "ready", {7'd0, g[10]}, {7'd0, e[10]});
        check_one(id, "upd_ready", {7'd0, g[11]}, {7'd0, e[11]});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0)
                check_all(0, exp_q0.pop_front(), {upd_ready0, ready0, blank0, dec0, ena0});
            if (exp_q1.size() > 0)
                check_all(1, exp_q1.pop_front(), {upd_ready1, ready1, blank1, dec1, ena1});
        end
    end

    task automatic drive(input logic r, input logic e, input logic v, input logic [2:0] c,
                         input int n);
        rst       = r;
        en        = e;
        upd_valid = v;
        otrip_in  = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with en held high, then power up on code 0.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 3);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 20);
        // Code 5 loaded while off, then enable.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2);
        drive(1'b0, 1'b0, 1'b1, 3'd5, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 20);
        // Tap change 5 -> 2, then a same-code transfer.
        drive(1'b0, 1'b1, 1'b1, 3'd2, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 18);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 4);
        // en dropped part-way through a settle, then a full settle again.
        drive(1'b0, 1'b1, 1'b1, 3'd3, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 6);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 20);
        // Transfer on the same edge as enable.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2);
        drive(1'b0, 1'b1, 1'b1, 3'd6, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 18);
        // Transfer coinciding with en falling in ACTIVE still updates the code.
        drive(1'b0, 1'b0, 1'b1, 3'd1, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 18);
        // Reset mid-settle.
        drive(1'b0, 1'b1, 1'b1, 3'd4, 1);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 20);
        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic e;
            e = en;
            if ($urandom_range(0, 39) == 0) e = ~en;
            drive(($urandom_range(0, 299) == 0), e, ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), 1);
        end
        drive(1'b0, 1'b1, 1'b0, 3'd0, 2);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
